// File: rtl/pe_pair_scheduler.sv
// Issue scheduler for the PE0/PE1 Givens-rotation pair: one op per cycle, RAW hazard
// stalls, forward-on-write-back issue, and write-back strobes from an in-flight tracker.
module pe_pair_scheduler #(
    parameter int PE_LATENCY = 8,
    parameter int TILE_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [1:0]        op_scheme0_i,
    input  logic [1:0]        op_scheme1_i,
    input  logic [TILE_W-1:0] op_tile_i,
    input  logic              op_fwd_i,
    input  logic              op_swap_i,
    input  logic              op_last_i,
    output logic [1:0]        pe0_valid_o,
    output logic [1:0]        pe1_valid_o,
    output logic [1:0]        pe0_scheme_o,
    output logic [1:0]        pe1_scheme_o,
    output logic [TILE_W-1:0] rd_tile_o,
    output logic              rd_fwd_o,
    output logic              rd_swap_o,
    output logic              wb_en_o,
    output logic [TILE_W-1:0] wb_tile_o,
    output logic              wb_swap_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              fwd_miss_o
);

    // Tracker slot i holds the op issued i+1 cycles ago; the top slot writes back next cycle.
    logic [PE_LATENCY-1:0] trk_vld;
    logic [PE_LATENCY-1:0] trk_last;
    logic [PE_LATENCY-1:0] trk_swap;
    logic [TILE_W-1:0]     trk_tile [PE_LATENCY];

    logic hit;
    logic hit_at_wb;
    logic accept;
    logic clr_last;
    logic wb_last_q;
    logic done_nxt;

    // Youngest same-tile entry wins: scan oldest to youngest so the last match sticks.
    always_comb begin
        hit       = 1'b0;
        hit_at_wb = 1'b0;
        for (int i = PE_LATENCY - 1; i >= 0; i--) begin
            if (trk_vld[i] && (trk_tile[i] == op_tile_i)) begin
                hit       = 1'b1;
                hit_at_wb = (i == PE_LATENCY - 1);
            end
        end
    end

    assign op_ready_o = rst_n & (op_fwd_i ? (~hit | hit_at_wb) : ~hit);
    assign accept     = op_valid_i & op_ready_o;
    // A newer last op retires the done obligation of every older last op.
    assign clr_last   = accept & op_last_i;
    assign done_nxt   = wb_en_o & wb_last_q & ~clr_last;

    // Stage p0: accept -> issue registers and tracker entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld      <= '0;
            trk_last     <= '0;
            pe0_valid_o  <= 2'b00;
            pe1_valid_o  <= 2'b00;
            pe0_scheme_o <= 2'b00;
            pe1_scheme_o <= 2'b00;
            rd_tile_o    <= '0;
            rd_fwd_o     <= 1'b0;
            rd_swap_o    <= 1'b0;
            fwd_miss_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            trk_vld      <= {trk_vld[PE_LATENCY-2:0], accept};
            trk_last     <= {trk_last[PE_LATENCY-2:0] & ~{(PE_LATENCY-1){clr_last}}, clr_last};
            pe0_valid_o  <= {2{accept}};
            pe1_valid_o  <= {2{accept}};
            pe0_scheme_o <= accept ? op_scheme0_i : 2'b00;
            pe1_scheme_o <= accept ? op_scheme1_i : 2'b00;
            rd_tile_o    <= accept ? op_tile_i : '0;
            rd_fwd_o     <= accept & op_fwd_i & hit;
            rd_swap_o    <= accept & op_swap_i;
            fwd_miss_o   <= fwd_miss_o | (accept & op_fwd_i & ~hit);
            busy_o       <= accept | (busy_o & ~done_nxt);
        end
    end

    // Tracker payload only matters under trk_vld, so it is left unreset.
    always_ff @(posedge clk) begin
        trk_tile[0] <= op_tile_i;
        for (int i = 1; i < PE_LATENCY; i++) begin
            trk_tile[i] <= trk_tile[i-1];
        end
        trk_swap <= {trk_swap[PE_LATENCY-2:0], op_swap_i};
    end

    // Stage p1: tracker top -> write-back strobe; write-back -> done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_o   <= 1'b0;
            wb_tile_o <= '0;
            wb_swap_o <= 1'b0;
            wb_last_q <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            wb_en_o   <= trk_vld[PE_LATENCY-1];
            wb_tile_o <= trk_vld[PE_LATENCY-1] ? trk_tile[PE_LATENCY-1] : '0;
            wb_swap_o <= trk_vld[PE_LATENCY-1] & trk_swap[PE_LATENCY-1];
            wb_last_q <= trk_vld[PE_LATENCY-1] & trk_last[PE_LATENCY-1] & ~clr_last;
            done_o    <= done_nxt;
        end
    end

endmodule
